// File: rtl/fp_normalize_pkg.sv
// Shared FPU constants: LFSR feedback mask, default seed and the signed exponent type.
// Also holds the Galois LFSR step function used by the normalisation stage.
package fpu_pkg;

    localparam logic [15:0] LfsrMask        = 16'hB400;
    localparam logic [15:0] LfsrSeedDefault = 16'hACE1;
    localparam int unsigned ExpWidthDefault = 8;

    typedef logic signed [ExpWidthDefault+1:0] exp_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LfsrMask) : (s >> 1);
    endfunction

endpackage

// File: rtl/fp_normalize_if.sv
// Upstream/downstream valid-ready bundle of the normalisation stage.
// The master drives operations in and accepts results; the slave is the stage itself.
interface fp_normalize_if #(
    parameter int unsigned mant_width     = 24,
    parameter int unsigned num_round_bits = 3,
    parameter int unsigned exp_width      = 8,
    parameter int unsigned in_width       = 48
);
    logic                                     in_valid;
    logic                                     in_ready;
    logic                                     in_sign;
    logic signed [exp_width+1:0]              in_exp;
    logic [in_width-1:0]                      in_mant;
    logic                                     in_stochastic;

    logic                                     out_valid;
    logic                                     out_ready;
    logic                                     out_sign;
    logic signed [exp_width+1:0]              out_exp;
    logic [mant_width+num_round_bits-1:0]     out_mant;
    logic [num_round_bits-1:0]                out_rand;
    logic                                     out_stochastic;
    logic                                     out_zero;
    logic                                     out_underflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_stochastic, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_rand,
               out_stochastic, out_zero, out_underflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_stochastic, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_rand,
               out_stochastic, out_zero, out_underflow
    );
endinterface

// File: rtl/fp_normalize_lzc.sv
// Parameterised leading-zero counter; an all-zero input reports width.
module lzc #(
    parameter int unsigned width = 48,
    localparam int unsigned CntW = $clog2(width + 1)
) (
    input  logic [width-1:0] i_data,
    output logic [CntW-1:0]  o_count
);
    // Scan upward so the highest set bit has the final say.
    always_comb begin
        o_count = CntW'(width);
        for (int unsigned i = 0; i < width; i++) begin
            if (i_data[i]) o_count = CntW'(width - 1 - i);
        end
    end
endmodule

// File: rtl/fp_normalize.sv
// Two-stage normaliser: S1 registers the op, its leading-zero count and LFSR word;
// S2 left-justifies, folds sticky bits, adjusts the exponent and flushes underflow.
module fp_normalize
    import fpu_pkg::*;
#(
    parameter int unsigned mant_width     = 24,
    parameter int unsigned num_round_bits = 3,
    parameter int unsigned exp_width      = 8,
    parameter int unsigned in_width       = 48,
    parameter logic [15:0] lfsr_seed      = LfsrSeedDefault
) (
    input logic          clk,
    input logic          rst,
    fp_normalize_if.slave bus
);
    localparam int unsigned OW  = mant_width + num_round_bits;
    localparam int unsigned EW  = exp_width + 2;
    localparam int unsigned LzW = $clog2(in_width + 1);

    logic                      w_s2_adv, w_s1_adv, w_accept;
    logic [LzW-1:0]            w_lz;
    logic [in_width-1:0]       w_shifted;
    logic [in_width:0]         w_ext;
    logic [OW-1:0]             w_mant;
    logic signed [31:0]        w_exp_ext, w_lz_ext, w_exp_diff;
    logic                      w_zero, w_uf;

    logic                      r_lfsr_unused_guard;
    logic [15:0]               r_lfsr;
    logic                      r_s1_valid, r_s1_sign, r_s1_stoch;
    logic signed [EW-1:0]      r_s1_exp;
    logic [in_width-1:0]       r_s1_mant;
    logic [LzW-1:0]            r_s1_lz;
    logic [num_round_bits-1:0] r_s1_rand;

    logic                      r_out_valid, r_out_sign, r_out_stoch, r_out_zero, r_out_uf;
    logic signed [EW-1:0]      r_out_exp;
    logic [OW-1:0]             r_out_mant;
    logic [num_round_bits-1:0] r_out_rand;

    assign w_s2_adv     = !r_out_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign w_accept     = bus.in_valid && w_s1_adv;
    assign bus.in_ready = w_s1_adv;

    lzc #(.width(in_width)) u_lzc (
        .i_data  (bus.in_mant),
        .o_count (w_lz)
    );

    // A zero appended below keeps the sticky slice legal when in_width == OW.
    assign w_shifted = r_s1_mant << r_s1_lz;
    assign w_ext     = {w_shifted, 1'b0};
    assign w_mant    = w_ext[in_width -: OW] | {{(OW-1){1'b0}}, |w_ext[in_width-OW:0]};

    assign w_exp_ext  = 32'(r_s1_exp);
    assign w_lz_ext   = 32'(r_s1_lz);
    assign w_exp_diff = w_exp_ext - w_lz_ext;
    assign w_zero     = (r_s1_lz == LzW'(in_width));
    assign w_uf       = !w_zero && (w_exp_diff <= 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr      <= lfsr_seed;
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_stoch  <= 1'b0;
            r_s1_exp    <= '0;
            r_s1_mant   <= '0;
            r_s1_lz     <= '0;
            r_s1_rand   <= '0;
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_stoch <= 1'b0;
            r_out_zero  <= 1'b0;
            r_out_uf    <= 1'b0;
            r_out_exp   <= '0;
            r_out_mant  <= '0;
            r_out_rand  <= '0;
        end else begin
            if (w_s1_adv) r_s1_valid <= bus.in_valid;
            if (w_accept) begin
                r_s1_sign  <= bus.in_sign;
                r_s1_stoch <= bus.in_stochastic;
                r_s1_exp   <= bus.in_exp;
                r_s1_mant  <= bus.in_mant;
                r_s1_lz    <= w_lz;
                r_s1_rand  <= r_lfsr[num_round_bits-1:0];
                r_lfsr     <= lfsr_next(r_lfsr);
            end
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_sign  <= r_s1_sign;
                    r_out_stoch <= r_s1_stoch;
                    r_out_rand  <= r_s1_rand;
                    r_out_zero  <= w_zero;
                    r_out_uf    <= w_uf;
                    r_out_mant  <= (w_zero || w_uf) ? '0 : w_mant;
                    r_out_exp   <= (w_zero || w_uf) ? '0 : w_exp_diff[EW-1:0];
                end
            end
        end
    end

    assign r_lfsr_unused_guard = 1'b0;

    assign bus.out_valid      = r_out_valid;
    assign bus.out_sign       = r_out_sign;
    assign bus.out_exp        = r_out_exp;
    assign bus.out_mant       = r_out_mant;
    assign bus.out_rand       = r_out_rand;
    assign bus.out_stochastic = r_out_stoch;
    assign bus.out_zero       = r_out_zero;
    assign bus.out_underflow  = r_out_uf;
endmodule

// File: tb/tb_fp_normalize.sv
// Bench for fp_normalize: directed cases, stall/reset scenarios and randomized traffic
// checked against a normalise-by-repeated-doubling reference model and scoreboard.
module tb_fp_normalize;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_normalize_if #(
        .mant_width(24), .num_round_bits(3), .exp_width(8), .in_width(48)
    ) bus ();

    fp_normalize #(
        .mant_width(24), .num_round_bits(3), .exp_width(8), .in_width(48),
        .lfsr_seed(16'hACE1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [26:0] mant;
        logic [2:0]  rnd;
        logic        stoch;
        logic        zero;
        logic        uf;
    } rec_t;

    int          errors = 0;
    int          checks = 0;
    int          n_acc  = 0;
    rec_t        q[$];
    rec_t        held;
    logic        stalled = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: double the significand until its top bit is set, counting the doublings.
    function automatic rec_t model(input logic s, input logic signed [9:0] e,
                                   input logic [47:0] m, input logic st,
                                   input logic [2:0] rnd);
        rec_t        r;
        logic [47:0] n;
        int          lz;
        int          ex;
        r = '0;
        r.sign = s;
        r.stoch = st;
        r.rnd = rnd;
        n = m;
        lz = 0;
        if (m == 48'd0) begin
            r.zero = 1'b1;
        end else begin
            while (!n[47]) begin
                n = n << 1;
                lz++;
            end
            ex = int'(e) - lz;
            if (ex <= 0) begin
                r.uf = 1'b1;
            end else begin
                r.exp  = ex[9:0];
                r.mant = n[47:21] | ((n[20:0] != 21'd0) ? 27'd1 : 27'd0);
            end
        end
        return r;
    endfunction

    function automatic rec_t dut_rec();
        rec_t r;
        r.sign  = bus.out_sign;
        r.exp   = bus.out_exp;
        r.mant  = bus.out_mant;
        r.rnd   = bus.out_rand;
        r.stoch = bus.out_stochastic;
        r.zero  = bus.out_zero;
        r.uf    = bus.out_underflow;
        return r;
    endfunction

    task automatic sample();
        rec_t cur;
        rec_t e;
        cur = dut_rec();
        if (stalled) begin
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_stable", 64'(cur), 64'(held));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                check("out_unexpected", 64'(bus.out_valid), 64'd0);
            end else begin
                e = q.pop_front();
                check("sb_sign", 64'(cur.sign), 64'(e.sign));
                check("sb_exp", 64'(cur.exp), 64'(e.exp));
                check("sb_mant", 64'(cur.mant), 64'(e.mant));
                check("sb_rand", 64'(cur.rnd), 64'(e.rnd));
                check("sb_stoch", 64'(cur.stoch), 64'(e.stoch));
                check("sb_zero", 64'(cur.zero), 64'(e.zero));
                check("sb_uf", 64'(cur.uf), 64'(e.uf));
            end
        end
        stalled = bus.out_valid && !bus.out_ready;
        held = cur;
        if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant, bus.in_stochastic,
                              m_lfsr[2:0]));
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            n_acc++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                         input logic st);
        bus.in_sign       = s;
        bus.in_exp        = e;
        bus.in_mant       = m;
        bus.in_stochastic = st;
    endtask

    task automatic directed(input string tag, input logic s, input logic signed [9:0] e,
                            input logic [47:0] m, input logic st, input logic [26:0] xm,
                            input logic [9:0] xe, input logic xz, input logic xu,
                            input int xr);
        int n;
        drive(s, e, m, st);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n + 1), 64'd2);
        check({tag, "_mant"}, 64'(bus.out_mant), 64'(xm));
        check({tag, "_exp"}, 64'(bus.out_exp), 64'(xe));
        check({tag, "_zero"}, 64'(bus.out_zero), 64'(xz));
        check({tag, "_uf"}, 64'(bus.out_underflow), 64'(xu));
        check({tag, "_sign"}, 64'(bus.out_sign), 64'(s));
        check({tag, "_stoch"}, 64'(bus.out_stochastic), 64'(st));
        if (xr >= 0) check({tag, "_rand"}, 64'(bus.out_rand), 64'(xr));
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 40) begin
            tick();
            n++;
        end
        check(tag, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int          acc0;
        logic [63:0] tmp;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 10'sd0, 48'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_data", 64'(dut_rec()), 64'd0);
        rst = 1'b0;
        tick();

        directed("d_norm", 1'b0, 10'sd100, 48'h0000_0100_0000, 1'b0, 27'h400_0000,
                 10'd77, 1'b0, 1'b0, 1);
        directed("d_sticky", 1'b1, 10'sd130, 48'h8000_0000_0001, 1'b1, 27'h400_0001,
                 10'd130, 1'b0, 1'b0, 0);
        directed("d_zero", 1'b0, 10'sd55, 48'd0, 1'b1, 27'd0, 10'd0, 1'b1, 1'b0, -1);
        directed("d_uf", 1'b0, 10'sd20, 48'h0000_0000_0001, 1'b0, 27'd0, 10'd0, 1'b0,
                 1'b1, -1);
        directed("d_uf_edge", 1'b1, 10'sd0, 48'h8000_0000_0000, 1'b0, 27'd0, 10'd0,
                 1'b0, 1'b1, -1);
        directed("d_exp_one", 1'b0, 10'sd2, 48'h4000_0000_0000, 1'b1, 27'h400_0000,
                 10'd1, 1'b0, 1'b0, -1);
        directed("d_neg_exp", 1'b1, -10'sd5, 48'hFFFF_FFFF_FFFF, 1'b0, 27'd0, 10'd0,
                 1'b0, 1'b1, -1);

        // Stall: two ops fill the pipe, then the input side must back off.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            tmp = {$urandom, $urandom};
            drive(1'($urandom), 10'sd300, tmp[47:0], 1'($urandom));
            tick();
        end
        check("stall_accepts", 64'(n_acc - acc0), 64'd2);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain("stall_drain");

        // Reset with two ops in flight.
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        q.delete();
        stalled = 1'b0;
        m_lfsr = 16'hACE1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        directed("d_after_rst", 1'b0, 10'sd100, 48'h0000_0100_0000, 1'b0, 27'h400_0000,
                 10'd77, 1'b0, 1'b0, 1);

        for (int i = 0; i < 400; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tmp = {$urandom, $urandom};
            tmp = tmp >> $urandom_range(16, 63);
            if ($urandom_range(0, 7) == 0) tmp = 64'd0;
            drive(1'($urandom), 10'($urandom), tmp[47:0], 1'($urandom));
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_normalize.md
# fp_normalize

Pipelined normalisation stage that sits directly upstream of the rounding stage. It takes a raw wide significand from the arithmetic datapath (product or sum), left-justifies it and adjusts the exponent. It folds discarded low bits into a sticky bit and emits a `mant_width+num_round_bits` mantissa ready for rounding. It also owns the LFSR that supplies per-operation random bits for stochastic rounding, so each transaction carries its own random word downstream.

## Interface
Parameters:
- `mant_width`, 24: significand width including hidden bit.
- `num_round_bits`, 3: guard/round bits passed to rounding; 1..16.
- `exp_width`, 8: IEEE exponent field width; the internal exponent is signed, `exp_width+2` bits.
- `in_width`, 48: raw significand width; must be >= `mant_width+num_round_bits`.
- `lfsr_seed`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: upstream data valid.
- `in_ready` out 1: stage can accept.
- `in_sign` in 1: sign.
- `in_exp` in `exp_width+2`: signed biased exponent of `in_mant` bit `in_width-1`.
- `in_mant` in `in_width`: raw significand.
- `in_stochastic` in 1: rounding mode for this op.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_sign` out 1: sign.
- `out_exp` out `exp_width+2`: adjusted exponent.
- `out_mant` out `mant_width+num_round_bits`: normalised mantissa; MSB is the hidden bit; LSB includes sticky.
- `out_rand` out `num_round_bits`: random bits for this op.
- `out_stochastic` out 1: mode passed through.
- `out_zero` out 1: input significand was zero.
- `out_underflow` out 1: result flushed to zero.

## Operation
- Stage 1 (S1): register inputs, `lz` = leading-zero count of `in_mant` (0..`in_width`), and the LFSR word.
- Stage 2 (S2): shift left by `lz`. `out_mant` = top `mant_width+num_round_bits` bits of the shifted value. The LSB is ORed with the OR of all remaining lower bits (sticky).
- `out_exp = in_exp - lz`, computed signed at full width with no wrap.
- Zero input (`in_mant==0`): `out_zero=1`, `out_mant=0`, `out_exp=0`, `out_underflow=0`.
- Underflow (nonzero input, `in_exp - lz <= 0`): `out_underflow=1`, `out_mant=0`, `out_exp=0`. No subnormals are produced.
- Overflow is not detected here; it is left to the pack stage.
- LFSR: 16-bit Galois, right-shift, feedback mask 16'hB400. If the current LSB is 1, the next state is `(s>>1)^16'hB400`, else `s>>1`.
  - The LFSR advances exactly once per accepted input (`in_valid && in_ready`) and holds otherwise.
  - That op's `out_rand` is the low `num_round_bits` of the state before the advance.
  - The LFSR advances regardless of `in_stochastic`.
- `out_sign` and `out_stochastic` pass through unchanged.

## Timing
- Latency: 2 cycles from input accept to `out_valid` when there is no stall. Throughput: 1 op/cycle.
- Handshake:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv`.
  - `in_ready` must not depend combinationally on `in_valid`.
- While `out_valid && !out_ready`, all outputs hold stable.
- Simultaneous accept and emit in one cycle with a full pipe is legal and loses no data.
- Reset values:
  - `out_valid=0`, `in_ready=1`.
  - All data outputs are 0, except that internal LFSR state = `lfsr_seed`.
- Reset asserted mid-operation discards all in-flight ops. The LFSR restarts from the seed.

## Structure
- Shared package `fpu_pkg`: LFSR feedback mask constant, default seed, signed exponent typedef.
- One sub-module `lzc` (parameterised leading-zero counter, width `in_width`, output `$clog2(in_width+1)` bits), instantiated in S1.
- Shifter, sticky reduction, LFSR and handshake stay inline.

## Test plan
All scenarios use default parameters.
- `in_mant=48'h0000_0100_0000`, `in_exp=100` -> after 2 cycles `out_mant=27'h400_0000`, `out_exp=77`, `out_zero=0`.
- `in_mant=48'h8000_0000_0001`, `in_exp=130` -> `out_mant=27'h400_0001` (sticky set), `out_exp=130`.
- `in_mant=0` -> `out_zero=1`, `out_mant=0`, `out_exp=0`. `in_mant=48'h0000_0000_0001`, `in_exp=20` -> `out_underflow=1`, `out_mant=0`.
- Two ops accepted after reset -> `out_rand=3'b001` (from 16'hACE1), then `3'b000` (from 16'hE270).
- Hold `out_ready=0` for 5 cycles with `in_valid=1` -> `in_ready` drops after 2 ops are buffered and outputs stay stable. Release `out_ready` -> ops emerge in order with no loss or duplication, and the LFSR advances exactly once per op.
- Assert `rst` with 2 ops in flight -> `out_valid=0` immediately. The next op after release gets `out_rand=3'b001`.
